// File: rtl/booth_radix4_seq_if.sv
// Operand/product handshake bundle for booth_radix4_seq.
// master = operand producer / product consumer, slave = the multiplier.
interface booth_radix4_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, multiplicand, multiplier, is_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, is_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, 2 multiplier bits per clock.
// valid/ready on both operand and product sides; WIDTH must match the bus interface.
module booth_radix4_seq #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    booth_radix4_seq_if.slave bus
);
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("booth_radix4_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [2*E+1:0]       pp;
    logic [E:0]           m_pos, m_neg, m2_pos, m2_neg;
    logic [CW-1:0]        step;
    logic [2*WIDTH-1:0]   prod_r;

    logic [E-1:0]         m_ext, a_ext;
    logic [E:0]           addend, acc_sum;
    logic [2*E+1:0]       pp_add, pp_shift;
    logic                 accept, last_step;

    // pp layout: {acc[E:0], multiplier[E-1:0], guard}
    always_comb begin
        m_ext = bus.is_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                              : {2'b00, bus.multiplicand};
        a_ext = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                              : {2'b00, bus.multiplier};

        case (pp[2:0])
            3'b001, 3'b010: addend = m_pos;
            3'b011:         addend = m2_pos;
            3'b100:         addend = m2_neg;
            3'b101, 3'b110: addend = m_neg;
            default:        addend = '0;
        endcase

        acc_sum  = pp[2*E+1:E+1] + addend;
        pp_add   = {acc_sum, pp[E:0]};
        pp_shift = {{2{acc_sum[E]}}, pp_add[2*E+1:2]};
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (step == CW'(N - 1)) begin
                    last_step = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.product   = prod_r;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pp     <= '0;
            m_pos  <= '0;
            m_neg  <= '0;
            m2_pos <= '0;
            m2_neg <= '0;
            step   <= '0;
            prod_r <= '0;
        end else if (accept) begin
            pp     <= {{(E+1){1'b0}}, a_ext, 1'b0};
            m_pos  <= {m_ext[E-1], m_ext};
            m_neg  <= -{m_ext[E-1], m_ext};
            m2_pos <= {m_ext, 1'b0};
            m2_neg <= -{m_ext, 1'b0};
            step   <= '0;
        end else if (state == RUN) begin
            pp   <= pp_shift;
            step <= step + 1'b1;
            if (last_step) prod_r <= pp_shift[2*WIDTH:1];
        end
    end
endmodule

// File: tb/tb_booth_radix4_seq.sv
// Scoreboard bench for booth_radix4_seq at WIDTH 8, 16 and 4.
// Drivers push expected products; per-width monitors pop and compare on each output handshake.
module tb_booth_radix4_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    booth_radix4_seq_if #(.WIDTH(8))  ifc8 ();
    booth_radix4_seq_if #(.WIDTH(16)) ifc16 ();
    booth_radix4_seq_if #(.WIDTH(4))  ifc4 ();

    booth_radix4_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(ifc8.slave));
    booth_radix4_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(ifc16.slave));
    booth_radix4_seq #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(ifc4.slave));

    int compared = 0;
    int mismatched = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];
    logic [7:0]  q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string what);
        compared++;
        mismatched++;
        $display("FAIL %s", what);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] a,
                                            input int w, input logic s);
        longint mm, aa;
        logic [63:0] p;
        mm = longint'({32'b0, m});
        aa = longint'({32'b0, a});
        if (s && m[w-1]) mm = mm - (longint'(1) << w);
        if (s && a[w-1]) aa = aa - (longint'(1) << w);
        p = 64'(mm * aa);
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Monitors: handshake values are stable from the falling edge to the next rising edge
    always @(negedge clk) begin
        if (!reset && ifc8.out_valid && ifc8.out_ready) begin
            if (q8.size() == 0) fail_now($sformatf("w8 unexpected product 0x%0h", ifc8.product));
            else check("w8 product", 64'(ifc8.product), 64'(q8.pop_front()));
        end
        if (!reset && ifc16.out_valid && ifc16.out_ready) begin
            if (q16.size() == 0) fail_now($sformatf("w16 unexpected product 0x%0h", ifc16.product));
            else check("w16 product", 64'(ifc16.product), 64'(q16.pop_front()));
        end
        if (!reset && ifc4.out_valid && ifc4.out_ready) begin
            if (q4.size() == 0) fail_now($sformatf("w4 unexpected product 0x%0h", ifc4.product));
            else check("w4 product", 64'(ifc4.product), 64'(q4.pop_front()));
        end
    end

    task automatic issue8(input logic [7:0] m, input logic [7:0] a, input logic s,
                          input logic [15:0] exp, input bit push, input bit hold, output time t_acc);
        bit ok = 0;
        ifc8.multiplicand = m; ifc8.multiplier = a; ifc8.is_signed = s; ifc8.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc8.in_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("w8 accept timeout");
        @(posedge clk);
        t_acc = $time;
        if (push) q8.push_back(exp);
        #1;
        if (!hold) ifc8.in_valid = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] m, input logic [15:0] a, input logic s,
                           input logic [31:0] exp, output time t_acc);
        bit ok = 0;
        ifc16.multiplicand = m; ifc16.multiplier = a; ifc16.is_signed = s; ifc16.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc16.in_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("w16 accept timeout");
        @(posedge clk);
        t_acc = $time;
        q16.push_back(exp);
        #1;
    endtask

    task automatic issue4(input logic [3:0] m, input logic [3:0] a, input logic s,
                          input logic [7:0] exp, output time t_acc);
        bit ok = 0;
        ifc4.multiplicand = m; ifc4.multiplier = a; ifc4.is_signed = s; ifc4.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc4.in_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("w4 accept timeout");
        @(posedge clk);
        t_acc = $time;
        q4.push_back(exp);
        #1;
    endtask

    task automatic wait_valid8(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (ifc8.out_valid) begin n = i; break; end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (q8.size() == 0 && q16.size() == 0 && q4.size() == 0) break;
            @(posedge clk); #1;
        end
        if (q8.size() != 0 || q16.size() != 0 || q4.size() != 0)
            fail_now($sformatf("drain timeout: pending w8=%0d w16=%0d w4=%0d",
                               q8.size(), q16.size(), q4.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        time t, t_prev;
        int n;
        logic [7:0]  r8m, r8a;
        logic [15:0] r16m, r16a;
        logic        rs;

        ifc8.in_valid = 0;  ifc8.multiplicand = '0;  ifc8.multiplier = '0;  ifc8.is_signed = 0;  ifc8.out_ready = 1;
        ifc16.in_valid = 0; ifc16.multiplicand = '0; ifc16.multiplier = '0; ifc16.is_signed = 0; ifc16.out_ready = 1;
        ifc4.in_valid = 0;  ifc4.multiplicand = '0;  ifc4.multiplier = '0;  ifc4.is_signed = 0;  ifc4.out_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("w8 reset in_ready", 64'(ifc8.in_ready), 64'd1);
        check("w8 reset out_valid", 64'(ifc8.out_valid), 64'd0);
        check("w8 reset product", 64'(ifc8.product), 64'd0);
        check("w16 reset in_ready", 64'(ifc16.in_ready), 64'd1);
        check("w16 reset out_valid", 64'(ifc16.out_valid), 64'd0);
        check("w16 reset product", 64'(ifc16.product), 64'd0);
        check("w4 reset in_ready", 64'(ifc4.in_ready), 64'd1);
        check("w4 reset out_valid", 64'(ifc4.out_valid), 64'd0);
        check("w4 reset product", 64'(ifc4.product), 64'd0);
        reset = 1'b0;

        // -3 * 5 signed, with latency
        issue8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1, 0, t);
        wait_valid8(n);
        check("w8 latency", 64'(n), 64'd5);
        wait_drain();

        // Extreme operands
        issue8(8'h80, 8'h80, 1'b1, 16'h4000, 1, 0, t);
        issue8(8'h80, 8'h80, 1'b0, 16'h4000, 1, 0, t);
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1, 0, t);
        issue8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1, 0, t);
        issue8(8'hFD, 8'h05, 1'b0, 16'h04F1, 1, 0, t);
        issue8(8'h7F, 8'h80, 1'b1, 16'hC080, 1, 0, t);
        wait_drain();

        // Backpressure: 12*11 held while in_valid pulses are ignored
        ifc8.out_ready = 1'b0;
        issue8(8'h0C, 8'h0B, 1'b0, 16'h0084, 1, 0, t);
        wait_valid8(n);
        check("w8 latency under backpressure", 64'(n), 64'd5);
        ifc8.multiplicand = 8'h01; ifc8.multiplier = 8'h01;
        for (int i = 0; i < 10; i++) begin
            ifc8.in_valid = i[0];
            check("w8 bp product", 64'(ifc8.product), 64'h0084);
            check("w8 bp out_valid", 64'(ifc8.out_valid), 64'd1);
            check("w8 bp in_ready", 64'(ifc8.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        ifc8.in_valid = 1'b0;
        ifc8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("w8 post-handshake out_valid", 64'(ifc8.out_valid), 64'd0);
        check("w8 post-handshake in_ready", 64'(ifc8.in_ready), 64'd1);
        check("w8 post-handshake product held", 64'(ifc8.product), 64'h0084);
        wait_drain();

        // Reset in flight: 7*9 must be discarded
        issue8(8'h07, 8'h09, 1'b0, 16'h003F, 0, 0, t);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("w8 mid-op reset in_ready", 64'(ifc8.in_ready), 64'd1);
        check("w8 mid-op reset out_valid", 64'(ifc8.out_valid), 64'd0);
        check("w8 mid-op reset product", 64'(ifc8.product), 64'd0);
        reset = 1'b0;
        issue8(8'h02, 8'h03, 1'b0, 16'h0006, 1, 0, t);
        wait_valid8(n);
        check("w8 latency after reset", 64'(n), 64'd5);
        wait_drain();

        // Back-to-back streams with in_valid held high
        for (int k = 0; k < 50; k++) begin
            r8m = 8'($urandom); r8a = 8'($urandom); rs = 1'($urandom_range(0, 1));
            t_prev = t;
            issue8(r8m, r8a, rs, 16'(ref_mul(32'(r8m), 32'(r8a), 8, rs)), 1, 1, t);
            if (k > 0) check("w8 accept interval", 64'(t - t_prev), 64'd70);
        end
        ifc8.in_valid = 1'b0;
        wait_drain();

        for (int k = 0; k < 20; k++) begin
            r16m = 16'($urandom); r16a = 16'($urandom); rs = 1'($urandom_range(0, 1));
            t_prev = t;
            issue16(r16m, r16a, rs, 32'(ref_mul(32'(r16m), 32'(r16a), 16, rs)), t);
            if (k > 0) check("w16 accept interval", 64'(t - t_prev), 64'd110);
        end
        ifc16.in_valid = 1'b0;
        wait_drain();

        // WIDTH=4 corners then exhaustive sweep
        issue4(4'h8, 4'h8, 1'b1, 8'h40, t);
        issue4(4'hF, 4'hF, 1'b0, 8'hE1, t);
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 16; m++) begin
                for (int a = 0; a < 16; a++) begin
                    t_prev = t;
                    issue4(4'(m), 4'(a), 1'(s), 8'(ref_mul(32'(m), 32'(a), 4, 1'(s))), t);
                    check("w4 accept interval", 64'(t - t_prev), 64'd50);
                end
            end
        end
        ifc4.in_valid = 1'b0;
        wait_drain();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/booth_radix4_seq.md
Name: booth_radix4_seq

Overview:
Parametrised sequential radix-4 Booth multiplier. Supports both signed and unsigned operands, configurable width, and valid/ready handshakes on input and output. It retires 2 multiplier bits per clock. It is the general-purpose successor to the team's fixed 4-bit Booth unit and sits behind datapath blocks that can absorb multi-cycle latency in exchange for area.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
multiplicand  input  WIDTH  operand M
multiplier  input  WIDTH  operand A
is_signed  input  1  1: two's-complement operands; 0: unsigned; sampled with operands
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  registered result M*A

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE
  - in_ready=1 (combinational from state)
  - out_valid=0
  - product=0
  - internal accumulator/counter cleared
  - Reset overrides every other event, including an in-flight operation, whose result is discarded and never presented.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid & in_ready at edge E0:
  - extend both operands to E=WIDTH+2 bits (sign-extend if is_signed, else zero-extend);
  - load the partial-product register {acc[E:0]=0, A_ext[E-1:0], guard=0}, where acc is E+1 bits;
  - latch M_ext and precompute M_ext, -M_ext, 2M_ext, -2M_ext at E+1 bits;
  - step counter = 0; go to RUN.
  - in_valid while not in IDLE is ignored (operands not captured).
- RUN: one Booth step per edge.
  - Decode the low 3 bits {A[1:0],guard}:
    - 000 / 111 -> +0
    - 001 / 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 / 110 -> -M
  - Add to acc (mod 2^(E+1)), then arithmetic-shift the whole register right by 2.
  - Step count N = E/2 = WIDTH/2+1.
  - At the edge performing step N:
    - product <= low 2*WIDTH bits of {acc,A} after the final shift;
    - state -> DONE.
  - Latency: out_valid is high in the cycle following edge E0+N (N cycles after acceptance; 5 for WIDTH=8).
- DONE: product held stable while out_valid=1 and out_ready=0 (unbounded backpressure).
  - On out_valid & out_ready: state -> IDLE, out_valid -> 0; product retains its value.
  - No same-cycle bypass: a new operand is accepted no earlier than the cycle after the output handshake.
  - Throughput: one result per N+2 cycles with out_ready tied high.
- Arithmetic:
  - Result is exact for all operand pairs in both modes, including signed minimum*minimum and unsigned max*max.
  - No overflow flag.
- is_signed mid-operation: has no effect; only the value captured at acceptance is used.
- X-safety: no X on outputs after reset, regardless of input X when in_valid=0.

Test Plan:
1. WIDTH=8, is_signed=1, M=-3 (0xFD), A=5 -> product=0xFFF1 (-15); out_valid rises exactly 5 cycles after the accepting edge.
2. WIDTH=8, is_signed=1, M=A=0x80 (-128) -> product=0x4000 (16384). With is_signed=0 and the same bits (128*128) -> 0x4000; with M=A=0xFF unsigned -> 0xFE01 (65025); signed -> 0x0001.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> product and out_valid stable, in_ready=0, and new in_valid pulses are ignored. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
4. Reset mid-operation: assert reset at step 2 of M=7,A=9 -> next cycle state IDLE, in_ready=1, out_valid=0, product=0; the following transaction M=2,A=3 returns 6 with normal latency.
5. Back-to-back with out_ready=1 and in_valid held high: 50 random signed/unsigned pairs at WIDTH=8 plus 20 at WIDTH=16, checked against a reference model. The interval between accepts must be exactly N+2 cycles.
6. WIDTH=4 corner sweep: all 256 pairs, both modes, exhaustive compare (signed -8*-8=0x40, unsigned 15*15=0xE1).
